// File: rtl/cgra_ctrl_pkg.sv
// Shared types and constants for the CGRA execution controller.
package cgra_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } exec_state_e;

    localparam int DEF_SYS_DWIDTH   = 32;
    localparam int DEF_CNT_WIDTH    = 16;
    localparam int DEF_DRAIN_CYCLES = 2;

    localparam int DRAIN_MIN = 1;
    localparam int DRAIN_MAX = 15;
    localparam int DRAIN_W   = 4;

    // Drain counter preload; out-of-range settings are clamped so the
    // controller always leaves DRAIN.
    function automatic logic [DRAIN_W-1:0] drain_preload(input int cycles);
        int c;
        c = (cycles < DRAIN_MIN) ? DRAIN_MIN :
            (cycles > DRAIN_MAX) ? DRAIN_MAX : cycles;
        return DRAIN_W'(c - 1);
    endfunction

endpackage

// File: rtl/cgra_step_counter.sv
// Loadable step up-counter; tc flags the final step of the loaded run length.
module cgra_step_counter #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic [CNT_WIDTH-1:0] len,
    input  logic                 en,
    output logic [CNT_WIDTH-1:0] cnt,
    output logic                 tc
);

    logic [CNT_WIDTH-1:0] last_q;

    // len is never 0 when loaded, so len-1 cannot wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            last_q <= '0;
        end else if (load) begin
            cnt    <= '0;
            last_q <= len - CNT_WIDTH'(1);
        end else if (en) begin
            cnt    <= cnt + CNT_WIDTH'(1);
        end
    end

    assign tc = (cnt == last_q);

endmodule

// File: rtl/cgra_exec_ctrl.sv
// Execution controller for the 3x3 torus PE array: run / drain / capture sequencing.
// Optional busy-cycle counter enabled by defining CGRA_EXEC_PERF_CNT_EN.
module cgra_exec_ctrl
    import cgra_ctrl_pkg::*;
#(
    parameter int SYS_DWIDTH   = DEF_SYS_DWIDTH,
    parameter int CNT_WIDTH    = DEF_CNT_WIDTH,
    parameter int DRAIN_CYCLES = DEF_DRAIN_CYCLES
) (
    input  logic                  Clk,
    input  logic                  Resetn,
    input  logic                  Start,
    input  logic [CNT_WIDTH-1:0]  Sched_Len,
    input  logic                  Abort,
    input  logic                  Host_Wr,
    input  logic [SYS_DWIDTH-1:0] Host_Data0,
    input  logic [SYS_DWIDTH-1:0] Host_Data1,
    output logic [SYS_DWIDTH-1:0] Data0_Load,
    output logic [SYS_DWIDTH-1:0] Data1_Load,
    input  logic [SYS_DWIDTH-1:0] Data0_Store,
    input  logic [SYS_DWIDTH-1:0] Data1_Store,
    output logic                  PE_Array_Busy,
    output logic [CNT_WIDTH-1:0]  Step_Cnt,
    output logic [SYS_DWIDTH-1:0] Result0,
    output logic [SYS_DWIDTH-1:0] Result1,
    output logic                  Ctrl_Busy,
    output logic                  Done
`ifdef CGRA_EXEC_PERF_CNT_EN
    ,
    output logic [31:0]           Perf_Cnt,
    input  logic                  Perf_Clr
`endif
);

    localparam logic [DRAIN_W-1:0] DRAIN_LOAD = drain_preload(DRAIN_CYCLES);

    exec_state_e        state_q, state_d;
    logic [DRAIN_W-1:0] drain_q;
    logic               step_load, step_en, step_tc;

    cgra_step_counter #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_step (
        .clk   (Clk),
        .rst_n (Resetn),
        .load  (step_load),
        .len   (Sched_Len),
        .en    (step_en),
        .cnt   (Step_Cnt),
        .tc    (step_tc)
    );

    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        step_load = 1'b0;
        step_en   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (Start && !Abort) begin
                    if (Sched_Len == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d   = ST_RUN;
                        step_load = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                // Last step holds its index through DRAIN.
                if (Abort)        state_d = ST_IDLE;
                else if (step_tc) state_d = ST_DRAIN;
                else              step_en = 1'b1;
            end
            ST_DRAIN: begin
                if (Abort)              state_d = ST_IDLE;
                else if (drain_q == '0) state_d = ST_DONE;
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            drain_q <= '0;
        end else if (state_q == ST_RUN && state_d == ST_DRAIN) begin
            drain_q <= DRAIN_LOAD;
        end else if (state_q == ST_DRAIN && drain_q != '0) begin
            drain_q <= drain_q - DRAIN_W'(1);
        end
    end

    // Status outputs are flops fed from the next state, not decodes of state_q.
    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            PE_Array_Busy <= 1'b0;
            Ctrl_Busy     <= 1'b0;
            Done          <= 1'b0;
        end else begin
            PE_Array_Busy <= (state_d == ST_RUN);
            Ctrl_Busy     <= (state_d != ST_IDLE);
            Done          <= (state_d == ST_DONE);
        end
    end

    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            Data0_Load <= '0;
            Data1_Load <= '0;
        end else if (Host_Wr) begin
            Data0_Load <= Host_Data0;
            Data1_Load <= Host_Data1;
        end
    end

    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            Result0 <= '0;
            Result1 <= '0;
        end else if (state_q == ST_DONE) begin
            Result0 <= Data0_Store;
            Result1 <= Data1_Store;
        end
    end

`ifdef CGRA_EXEC_PERF_CNT_EN
    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn)                             Perf_Cnt <= '0;
        else if (Perf_Clr)                       Perf_Cnt <= '0;
        else if (PE_Array_Busy && Perf_Cnt != '1) Perf_Cnt <= Perf_Cnt + 32'd1;
    end
`endif

endmodule

// File: tb/tb_cgra_exec_ctrl.sv
// Bench for cgra_exec_ctrl: vector table, hand corner sequences, random runs vs run-level model.
module tb_cgra_exec_ctrl;

    localparam int DW    = 32;
    localparam int CW    = 16;
    localparam int DRAIN = 2;

    logic          Clk = 1'b0;
    logic          Resetn, Start, Abort, Host_Wr;
    logic [CW-1:0] Sched_Len, Step_Cnt;
    logic [DW-1:0] Host_Data0, Host_Data1, Data0_Load, Data1_Load;
    logic [DW-1:0] Data0_Store, Data1_Store, Result0, Result1;
    logic          PE_Array_Busy, Ctrl_Busy, Done;
`ifdef CGRA_EXEC_PERF_CNT_EN
    logic [31:0]   Perf_Cnt;
    logic          Perf_Clr;
`endif

    cgra_exec_ctrl #(.SYS_DWIDTH(DW), .CNT_WIDTH(CW), .DRAIN_CYCLES(DRAIN)) dut (
        .Clk           (Clk),
        .Resetn        (Resetn),
        .Start         (Start),
        .Sched_Len     (Sched_Len),
        .Abort         (Abort),
        .Host_Wr       (Host_Wr),
        .Host_Data0    (Host_Data0),
        .Host_Data1    (Host_Data1),
        .Data0_Load    (Data0_Load),
        .Data1_Load    (Data1_Load),
        .Data0_Store   (Data0_Store),
        .Data1_Store   (Data1_Store),
        .PE_Array_Busy (PE_Array_Busy),
        .Step_Cnt      (Step_Cnt),
        .Result0       (Result0),
        .Result1       (Result1),
        .Ctrl_Busy     (Ctrl_Busy),
        .Done          (Done)
`ifdef CGRA_EXEC_PERF_CNT_EN
        ,
        .Perf_Cnt      (Perf_Cnt),
        .Perf_Clr      (Perf_Clr)
`endif
    );

    always #5 Clk = ~Clk;

    int compared = 0;
    int mismatched = 0;
    logic [DW-1:0] exp_ld0 = '0, exp_ld1 = '0, exp_res0 = '0, exp_res1 = '0;
    longint perf_exp = 0;
    bit rand_wr = 1'b1;

    typedef struct {
        int len;
        int mode;      // 0 none, 1 abort at step abort_at, 2 abort in first drain cycle
        int abort_at;
        int exp_busy;
        int exp_done;  // Done offset in cycles after Start, -1 = never
    } vec_t;
    vec_t vecs[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One cycle: sample at negedge, check load ports, then drive next inputs.
    task automatic tick();
        @(negedge Clk);
        chk("load0", Data0_Load, exp_ld0);
        chk("load1", Data1_Load, exp_ld1);
        if (rand_wr) begin
            Host_Wr = ($urandom_range(0, 3) == 0);
            if (Host_Wr) begin
                Host_Data0 = $urandom;
                Host_Data1 = $urandom;
                exp_ld0 = Host_Data0;
                exp_ld1 = Host_Data1;
            end
        end
        Data0_Store = $urandom;
        Data1_Store = $urandom;
    endtask

    task automatic do_run(input int len, input int mode, input int abort_at, input bit stray,
                          output int nbusy, output int done_k);
        bit ab_pend, ab;
        logic [DW-1:0] r0, r1;
        nbusy = 0; done_k = -1; ab_pend = 0; ab = 0; r0 = '0; r1 = '0;
        Start = 1'b1; Sched_Len = CW'(len); Abort = 1'b0;
        for (int k = 1; k <= len + 16; k++) begin
            tick();
            Start = 1'b0; Abort = 1'b0;
            if (ab_pend) begin
                chk("abort_busy_drop", PE_Array_Busy, 0);
                chk("abort_ctrl_idle", Ctrl_Busy, 0);
                ab = 1;
                break;
            end
            if (PE_Array_Busy) begin
                chk("step_cnt", Step_Cnt, nbusy);
                nbusy++;
            end else if (Ctrl_Busy && !Done) begin
                chk("step_hold_drain", Step_Cnt, nbusy - 1);
            end
            if (Done) begin
                done_k = k;
                chk("result0_before_capture", Result0, exp_res0);
                r0 = Data0_Store; r1 = Data1_Store;
                break;
            end
            if (mode == 1 && PE_Array_Busy && nbusy - 1 == abort_at) begin
                Abort = 1'b1; ab_pend = 1;
            end else if (mode == 2 && Ctrl_Busy && !PE_Array_Busy && nbusy > 0) begin
                Abort = 1'b1; ab_pend = 1;
            end else if (stray && Ctrl_Busy) begin
                Start = 1'b1; Sched_Len = CW'($urandom_range(0, 20));
            end
        end
        Start = 1'b0;
        if (ab) begin
            repeat (3) begin
                tick();
                chk("abort_no_done", Done, 0);
                chk("abort_res0_hold", Result0, exp_res0);
                chk("abort_res1_hold", Result1, exp_res1);
            end
        end else if (done_k > 0) begin
            tick();
            chk("done_one_cycle", Done, 0);
            chk("result0", Result0, r0);
            chk("result1", Result1, r1);
            exp_res0 = r0; exp_res1 = r1;
        end
    endtask

    task automatic run_and_check(input int len, input int mode, input int abort_at, input bit stray,
                                 input int exp_busy, input int exp_done);
        int nb, dk;
        do_run(len, mode, abort_at, stray, nb, dk);
        chk("busy_cycles", nb, exp_busy);
        chk("done_latency", dk, exp_done);
        perf_exp += exp_busy;
`ifdef CGRA_EXEC_PERF_CNT_EN
        chk("perf_cnt", Perf_Cnt, perf_exp);
`endif
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int nb, dk, len, mode, ab_at, eb, ed;
        bit aborted, seen;
        logic [DW-1:0] r0, r1;

        vecs[0] = '{5, 0, 0, 5, 5 + DRAIN + 1};
        vecs[1] = '{0, 0, 0, 0, 1};
        vecs[2] = '{10, 1, 2, 3, -1};
        vecs[3] = '{3, 0, 0, 3, 3 + DRAIN + 1};
        vecs[4] = '{1, 0, 0, 1, 1 + DRAIN + 1};
        vecs[5] = '{2, 1, 1, 2, -1};
        vecs[6] = '{3, 2, 0, 3, -1};
        vecs[7] = '{4, 0, 0, 4, 4 + DRAIN + 1};

        Resetn = 1'b0; Start = 1'b0; Abort = 1'b0; Host_Wr = 1'b0; Sched_Len = '0;
        Host_Data0 = '0; Host_Data1 = '0; Data0_Store = '0; Data1_Store = '0;
`ifdef CGRA_EXEC_PERF_CNT_EN
        Perf_Clr = 1'b0;
`endif
        #3;
        chk("rst_busy", PE_Array_Busy, 0);
        chk("rst_ctrl_busy", Ctrl_Busy, 0);
        chk("rst_done", Done, 0);
        chk("rst_step", Step_Cnt, 0);
        chk("rst_load0", Data0_Load, 0);
        chk("rst_result1", Result1, 0);
        repeat (2) @(negedge Clk);
        Resetn = 1'b1;

        // Vector table; Start is pulsed on every non-idle cycle to show it is ignored.
        foreach (vecs[i])
            run_and_check(vecs[i].len, vecs[i].mode, vecs[i].abort_at, 1'b1,
                          vecs[i].exp_busy, vecs[i].exp_done);

        // Start together with Abort in IDLE stays idle, for zero and nonzero lengths.
        for (int l = 0; l < 2; l++) begin
            Start = 1'b1; Abort = 1'b1; Sched_Len = CW'(l * 5);
            tick();
            Start = 1'b0; Abort = 1'b0;
            tick();
            chk("start_abort_idle", Ctrl_Busy, 0);
            chk("start_abort_no_done", Done, 0);
            chk("start_abort_no_busy", PE_Array_Busy, 0);
        end

        // Host operand write during RUN, then hold.
        rand_wr = 1'b0; Host_Wr = 1'b0;
        Start = 1'b1; Sched_Len = CW'(6);
        tick();
        Start = 1'b0;
        tick();
        chk("wr_in_run", PE_Array_Busy, 1);
        Host_Wr = 1'b1; Host_Data0 = 32'hDEADBEEF; Host_Data1 = 32'h12345678;
        exp_ld0 = 32'hDEADBEEF; exp_ld1 = 32'h12345678;
        tick();
        Host_Wr = 1'b0; Host_Data0 = 32'h0; Host_Data1 = 32'hFFFF_FFFF;
        tick();
        tick();
        seen = 0; r0 = '0; r1 = '0;
        for (int k = 0; k < 20 && !seen; k++) begin
            tick();
            if (Done) begin
                seen = 1; r0 = Data0_Store; r1 = Data1_Store;
            end
        end
        chk("wr_run_done_seen", seen, 1);
        tick();
        chk("wr_run_result0", Result0, r0);
        chk("wr_run_result1", Result1, r1);
        exp_res0 = r0; exp_res1 = r1;
        perf_exp += 6;
        rand_wr = 1'b1;

        // Random runs checked against the run-level model.
        for (int n = 0; n < 25; n++) begin
            len   = $urandom_range(0, 12);
            mode  = $urandom_range(0, 2);
            ab_at = $urandom_range(0, 13);
            aborted = (mode == 1 && ab_at < len) || (mode == 2 && len > 0);
            eb = (mode == 1 && ab_at < len) ? ab_at + 1 : len;
            ed = aborted ? -1 : ((len == 0) ? 1 : len + DRAIN + 1);
            run_and_check(len, mode, ab_at, $urandom_range(0, 1), eb, ed);
        end

`ifdef CGRA_EXEC_PERF_CNT_EN
        Perf_Clr = 1'b1;
        tick();
        Perf_Clr = 1'b0;
        chk("perf_clr", Perf_Cnt, 0);
        perf_exp = 0;
        run_and_check(4, 0, 0, 1'b0, 4, 4 + DRAIN + 1);
        run_and_check(7, 0, 0, 1'b0, 7, 7 + DRAIN + 1);
        chk("perf_two_runs", Perf_Cnt, 11);
        Perf_Clr = 1'b1;
        tick();
        Perf_Clr = 1'b0;
        chk("perf_clr_after", Perf_Cnt, 0);
        perf_exp = 0;
`endif

        // Asynchronous reset in the middle of a run.
        rand_wr = 1'b0; Host_Wr = 1'b0;
        Host_Data0 = 32'hA5A5_0001; Host_Data1 = 32'h5A5A_0002; Host_Wr = 1'b1;
        exp_ld0 = Host_Data0; exp_ld1 = Host_Data1;
        Start = 1'b1; Sched_Len = CW'(10);
        tick();
        Start = 1'b0; Host_Wr = 1'b0;
        tick();
        tick();
        chk("midrst_busy_before", PE_Array_Busy, 1);
        #2 Resetn = 1'b0;
        #1;
        chk("midrst_busy", PE_Array_Busy, 0);
        chk("midrst_ctrl_busy", Ctrl_Busy, 0);
        chk("midrst_done", Done, 0);
        chk("midrst_step", Step_Cnt, 0);
        chk("midrst_load0", Data0_Load, 0);
        chk("midrst_load1", Data1_Load, 0);
        chk("midrst_result0", Result0, 0);
        chk("midrst_result1", Result1, 0);
`ifdef CGRA_EXEC_PERF_CNT_EN
        chk("midrst_perf", Perf_Cnt, 0);
`endif
        exp_ld0 = '0; exp_ld1 = '0;
        @(negedge Clk);
        Resetn = 1'b1;
        tick();
        chk("post_rst_idle", Ctrl_Busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/cgra_exec_ctrl.md
# cgra_exec_ctrl

Execution controller for the 3x3 torus PE array. It sequences one kernel run:
- accepts a host start request with a schedule length;
- drives the array's shared `PE_Array_Busy` enable for exactly that many cycles;
- waits a fixed drain interval;
- captures both IO-PE store outputs and reports completion.

It also registers host operands onto the two array load ports. It sits between the host/DMA interface and the PE array top.

## Interface
- `SYS_DWIDTH`, 32, width of load/store data paths.
- `CNT_WIDTH`, 16, width of schedule-length and step counters.
- `DRAIN_CYCLES`, 2, idle cycles after the last busy cycle before results are captured (store-path latency); legal range 1..15.

Ports:
- `Clk`  in  1  system clock, all logic rising-edge.
- `Resetn`  in  1  asynchronous, active-low reset.
- `Start`  in  1  single-cycle run request, sampled only in IDLE.
- `Sched_Len`  in  CNT_WIDTH  number of array cycles to run, sampled with `Start`.
- `Abort`  in  1  terminate the current run.
- `Host_Wr`  in  1  operand write strobe.
- `Host_Data0`  in  SYS_DWIDTH  operand for load port 0.
- `Host_Data1`  in  SYS_DWIDTH  operand for load port 1.
- `Data0_Load`  out  SYS_DWIDTH  registered operand to array load port 0.
- `Data1_Load`  out  SYS_DWIDTH  registered operand to array load port 1.
- `Data0_Store`  in  SYS_DWIDTH  array store port 0.
- `Data1_Store`  in  SYS_DWIDTH  array store port 1.
- `PE_Array_Busy`  out  1  array run enable.
- `Step_Cnt`  out  CNT_WIDTH  current step index while busy.
- `Result0`  out  SYS_DWIDTH  captured `Data0_Store`.
- `Result1`  out  SYS_DWIDTH  captured `Data1_Store`.
- `Ctrl_Busy`  out  1  high in any state other than IDLE.
- `Done`  out  1  one-cycle completion pulse.
- `Perf_Cnt`  out  32  busy-cycle counter (only with `CGRA_EXEC_PERF_CNT_EN`).
- `Perf_Clr`  in  1  synchronous clear of `Perf_Cnt` (only with `CGRA_EXEC_PERF_CNT_EN`).

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE → RUN: `Start`=1, `Sched_Len`≠0, `Abort`=0. The step counter loads 0 and the remaining count loads `Sched_Len`.
- IDLE → DONE: `Start`=1 with `Sched_Len`=0. No busy cycles; results are recaptured.
- RUN:
  - `PE_Array_Busy`=1 and `Step_Cnt` increments by 1 per cycle.
  - → DRAIN after the cycle where `Step_Cnt`=`Sched_Len`-1. The drain counter loads `DRAIN_CYCLES`-1.
- DRAIN:
  - `PE_Array_Busy`=0 and `Step_Cnt` holds its last value.
  - Decrements each cycle; → DONE at 0.
- DONE:
  - `Done`=1 for one cycle.
  - `Result0`/`Result1` load `Data0_Store`/`Data1_Store` on the clock edge leaving DONE.
  - → IDLE unconditionally.
- `Start` outside IDLE is ignored; it is not queued.
- `Abort` in RUN or DRAIN: → IDLE next cycle. `PE_Array_Busy` drops, no `Done`, results unchanged. `Abort` in IDLE or DONE has no effect, except that `Abort`+`Start` in IDLE keeps IDLE.
- `Host_Wr`=1 in any state: `Data0_Load`/`Data1_Load` take `Host_Data0`/`Host_Data1` on the next edge. Otherwise they hold.
- Counters are unsigned. `Sched_Len` max is 2^CNT_WIDTH-1; no wrap occurs within a run.
- `Step_Cnt` resets to 0 on entry to RUN only.

## Timing
- Reset values: state IDLE; all outputs 0 (`PE_Array_Busy`, `Done`, `Ctrl_Busy`, `Step_Cnt`, `Data0_Load`, `Data1_Load`, `Result0`, `Result1`, `Perf_Cnt`).
- `Start` at edge t → `PE_Array_Busy` high from cycle t+1 through t+`Sched_Len`.
- `Done` is high in cycle t+`Sched_Len`+`DRAIN_CYCLES`+1; `Result*` are valid from the following cycle.
- Total latency from `Start` to `Done` is `Sched_Len`+`DRAIN_CYCLES`+1 cycles. A new `Start` is accepted in the cycle after `Done`.
- Reset asserted mid-run: all state clears immediately (asynchronous) and `PE_Array_Busy` drops without waiting for a clock.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- `CGRA_EXEC_PERF_CNT_EN` defined:
  - `Perf_Cnt`/`Perf_Clr` ports exist.
  - `Perf_Cnt` increments on every cycle with `PE_Array_Busy`=1 and saturates at 2^32-1.
  - `Perf_Clr` takes priority over the increment.
- Not defined: both ports and the counter are absent; all other behaviour is identical.

## Structure
- Package `cgra_ctrl_pkg` holds:
  - the state enum (IDLE, RUN, DRAIN, DONE);
  - the default width constants;
  - the `DRAIN_CYCLES` legal-range constant.
- One natural sub-module, `cgra_step_counter`: a loadable up-counter with terminal-count compare, used for `Step_Cnt`/run-length tracking.
- The FSM, drain counter, operand and result registers stay in the top.

## Test plan
- Reset, then `Start` with `Sched_Len`=5 and `DRAIN_CYCLES`=2:
  - `PE_Array_Busy` high for exactly 5 cycles and `Step_Cnt` steps 0..4;
  - `Done` 8 cycles after `Start`;
  - `Result0`/`Result1` = store values present in the DONE cycle.
- `Start` with `Sched_Len`=0 → no busy cycle, `Done` next cycle.
- `Abort` in RUN step 2 of 10 → busy drops next cycle, no `Done`, results unchanged. A following `Start` with length 3 runs normally.
- `Start` pulsed during RUN and DRAIN → ignored. Simultaneous `Start`+`Abort` in IDLE → stays IDLE.
- `Host_Wr` with 0xDEADBEEF/0x12345678 during RUN → load ports update next cycle and hold after `Host_Wr` drops.
- With `CGRA_EXEC_PERF_CNT_EN`: two runs of 4 and 7 → `Perf_Cnt`=11. `Perf_Clr` → 0. `Resetn` low mid-run → all outputs 0 immediately.
